// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC select
// encodings, fetch FSM states, the NOP encoding and small PC helpers.
package fetch_unit_pkg;

    // Next-PC select driven by the control unit
    typedef enum logic [1:0] {
        NPC_PC4  = 2'd0,
        NPC_IMM  = 2'd1,
        NPC_ALU  = 2'd2,
        NPC_RSVD = 2'd3
    } npc_op_e;

    // Fetch sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_ENC = 32'h0000_0013;

    // Sequential instruction stride in bytes
    localparam logic [31:0] PC_STEP = 32'h0000_0004;

    // jalr targets drop bit 0; masking keeps every operand bit in use
    function automatic logic [31:0] jalr_align(input logic [31:0] target);
        return target & 32'hFFFF_FFFE;
    endfunction

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// Combinational next-PC selection. All additions are 32-bit and wrap
// modulo 2^32; the reserved select falls back to sequential flow.
module npc_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  npc_op,
    input  logic [31:0] imm,
    input  logic [31:0] alu_c,
    output logic [31:0] next_pc,
    output logic [31:0] pc4
);

    logic [31:0] pc4_s;
    logic [31:0] pc_imm_s;

    // Candidate targets, truncated to 32 bits so overflow wraps
    always_comb begin
        pc4_s    = pc + PC_STEP;
        pc_imm_s = pc + imm;
    end

    // Select the next PC from the control unit encoding
    always_comb begin
        next_pc = pc4_s;
        case (npc_op)
            NPC_PC4: next_pc = pc4_s;
            NPC_IMM: next_pc = pc_imm_s;
            NPC_ALU: next_pc = jalr_align(alu_c);
            default: next_pc = pc4_s;
        endcase
    end

    assign pc4 = pc4_s;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one instruction at a time from
// instruction memory, holds it for decode until downstream retires it,
// then advances the PC to the target chosen by npc_calc.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_ENC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  npc_op,
    input  logic [31:0] imm,
    input  logic [31:0] alu_c,
    input  logic        ex_done,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic        inst_valid
);

    fetch_state_e state_q;
    fetch_state_e state_d;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] inst_q;
    logic [31:0] inst_d;
    logic        valid_q;
    logic        valid_d;

    logic [31:0] next_pc_s;
    logic        fetching_s;
    logic        load_inst_s;
    logic        retire_s;

    npc_calc u_npc_calc (
        .pc      (pc_q),
        .npc_op  (npc_op),
        .imm     (imm),
        .alu_c   (alu_c),
        .next_pc (next_pc_s),
        .pc4     (pc4)
    );

    // FSM state register; reset wins over any in-flight fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: ex_done only matters while an instruction is held
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (ex_done) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: memory request and datapath load enables
    always_comb begin
        fetching_s  = 1'b0;
        load_inst_s = 1'b0;
        retire_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                fetching_s = 1'b0;
            end
            ST_FETCH: begin
                fetching_s  = 1'b1;
                load_inst_s = imem_ready;
            end
            ST_HOLD: begin
                retire_s = ex_done;
            end
            default: begin
                fetching_s = 1'b0;
            end
        endcase
    end

    // Datapath next values: capture on fetch, advance PC on retire
    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (load_inst_s) begin
            inst_d  = imem_rdata;
            valid_d = 1'b1;
        end else if (retire_s) begin
            pc_d    = next_pc_s;
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else begin
            pc_d    = pc_q;
            inst_d  = inst_q;
            valid_d = valid_q;
        end
    end

    // Datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    // Request is suppressed while reset is asserted, even before the first edge
    assign imem_req   = fetching_s & ~rst;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign inst_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [1:0]  npc_op;
    logic [31:0] imm;
    logic [31:0] alu_c;
    logic        ex_done;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        inst_valid;

    int n_checks;
    int n_errors;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .npc_op     (npc_op),
        .imm        (imm),
        .alu_c      (alu_c),
        .ex_done    (ex_done),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .pc4        (pc4),
        .inst       (inst),
        .inst_valid (inst_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one edge and sample 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // retire the held instruction with the given next-PC select
    task automatic retire(input logic [1:0] op, input logic [31:0] im, input logic [31:0] ac);
        npc_op  = op;
        imm     = im;
        alu_c   = ac;
        ex_done = 1'b1;
        step();
        ex_done = 1'b0;
    endtask

    // complete a one-cycle fetch (must be in FETCH)
    task automatic fetch_one(input logic [31:0] data);
        imem_ready = 1'b1;
        imem_rdata = data;
        step();
        imem_ready = 1'b0;
    endtask

    // from HOLD, jump to target and refetch so that HOLD has pc=target
    task automatic goto_hold(input logic [31:0] target);
        retire(2'b10, 32'h0, target);
        fetch_one(32'h0000_0033);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        npc_op     = 2'b00;
        imm        = 32'h0;
        alu_c      = 32'h0;
        ex_done    = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'h0010_0093;

        // reset state
        step();
        step();
        check("rst_pc", pc, 32'h0);
        check("rst_inst", inst, NOP);
        check("rst_valid", {31'h0, inst_valid}, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_pc4", pc4, 32'h4);

        // IDLE then FETCH with ready every cycle
        rst = 1'b0;
        check("idle_req", {31'h0, imem_req}, 32'h0);
        step();
        check("fetch_req", {31'h0, imem_req}, 32'h1);
        check("fetch_addr", imem_addr, 32'h0);
        step();
        check("hold_inst", inst, 32'h0010_0093);
        check("hold_valid", {31'h0, inst_valid}, 32'h1);
        check("hold_req", {31'h0, imem_req}, 32'h0);
        imem_ready = 1'b0;

        // HOLD stays stable without ex_done
        imem_rdata = 32'hAAAA_5555;
        step();
        step();
        check("hold_stable_inst", inst, 32'h0010_0093);
        check("hold_stable_pc", pc, 32'h0);

        // sequential retire
        retire(2'b00, 32'h0, 32'h0);
        check("ret_pc", pc, 32'h4);
        check("ret_valid", {31'h0, inst_valid}, 32'h0);
        check("ret_inst", inst, NOP);

        // three wait cycles then ready: request and address held for 4 cycles
        imem_rdata = 32'h0020_0113;
        for (int i = 0; i < 4; i++) begin
            check("wait_req", {31'h0, imem_req}, 32'h1);
            check("wait_addr", imem_addr, 32'h4);
            check("wait_valid", {31'h0, inst_valid}, 32'h0);
            if (i == 3) imem_ready = 1'b1;
            step();
        end
        imem_ready = 1'b0;
        check("wait_done_valid", {31'h0, inst_valid}, 32'h1);
        check("wait_done_inst", inst, 32'h0020_0113);

        // branch, jalr and reserved selects from pc=0x100
        retire(2'b01, 32'h0000_00FC, 32'h0);
        check("to_100", pc, 32'h100);
        fetch_one(32'h0000_0033);
        retire(2'b01, 32'hFFFF_FFF8, 32'h0);
        check("npc_imm", pc, 32'hF8);
        fetch_one(32'h0000_0033);
        goto_hold(32'h100);
        retire(2'b10, 32'h0, 32'h203);
        check("npc_jalr", pc, 32'h202);
        fetch_one(32'h0000_0033);
        goto_hold(32'h100);
        retire(2'b11, 32'h0000_1000, 32'h0000_0400);
        check("npc_rsvd", pc, 32'h104);
        check("npc_rsvd_pc4", pc4, 32'h108);
        fetch_one(32'h0000_0033);

        // wrap at top of address space
        goto_hold(32'hFFFF_FFFC);
        check("wrap_pc4_pre", pc4, 32'h0);
        retire(2'b00, 32'h0, 32'h0);
        check("wrap_pc", pc, 32'h0);
        check("wrap_pc4", pc4, 32'h4);

        // ex_done during FETCH is ignored
        ex_done = 1'b1;
        npc_op  = 2'b01;
        imm     = 32'h40;
        step();
        check("exd_fetch_pc", pc, 32'h0);
        check("exd_fetch_valid", {31'h0, inst_valid}, 32'h0);
        check("exd_fetch_req", {31'h0, imem_req}, 32'h1);
        step();
        check("exd_fetch_pc2", pc, 32'h0);
        check("exd_fetch_addr", imem_addr, 32'h0);
        ex_done = 1'b0;
        fetch_one(32'h0000_0033);
        retire(2'b10, 32'h0, 32'h40);

        // reset colliding with ready in FETCH
        check("pre_rst_pc", pc, 32'h40);
        rst        = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        ex_done    = 1'b1;
        step();
        check("rstf_pc", pc, 32'h0);
        check("rstf_valid", {31'h0, inst_valid}, 32'h0);
        check("rstf_inst", inst, NOP);
        check("rstf_req", {31'h0, imem_req}, 32'h0);
        rst     = 1'b0;
        ex_done = 1'b0;
        // now IDLE: no request and late ready must not load
        check("post_rst_idle_req", {31'h0, imem_req}, 32'h0);
        step();
        check("post_rst_inst", inst, NOP);
        check("post_rst_valid", {31'h0, inst_valid}, 32'h0);
        check("post_rst_fetch_req", {31'h0, imem_req}, 32'h1);
        step();
        check("post_rst_load", inst, 32'hDEAD_BEEF);
        imem_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
